cram_diag_loader: RTL and testbench
===================================

# cram_diag_loader

Diagnostic CRAM loader/sequencer for the microcode address and storage path. It accepts one request: a microcode address plus an optional 80-bit CRAM word. It then drives the diagnostic function bus to load the CRA diagnostic address (functions 051/052) and reads the CRADR back through read function 14x to verify it. On a write request it then strobes the four CRAM write groups (00_19, 20_39, 40_59, 60_79). It sits between the DTE-side diagnostic master and the CTL/EBUS diagnostic signals, and owns the EBUS for the whole transaction.

## Interface
- STROBE_CYCLES, 2: cycles the load strobe stays high per load/write step (≥1)
- READ_CYCLES, 2: cycles the read enable stays high per verify step (≥1); sample taken on the last cycle
- clk  in  1  CRA-domain clock
- rstN  in  1  reset, asynchronous, active-low
- req  in  1  request valid; accepted when `req & ready`
- ready  out  1  high only in IDLE
- reqWrite  in  1  1 = address load + CRAM write; 0 = address load only
- reqAdr  in  11  [0:10] CRAM address
- reqData  in  80  [0:79] CRAM word, captured at accept
- done  out  1  one-cycle pulse at transaction end
- err  out  1  valid with `done`: address readback mismatch
- rdAdr  out  11  last readback address; holds until the next accept
- ebusReq  out  1  EBUS ownership request
- ebusGrant  in  1  EBUS grant
- diagSel  out  3  [4:6] function select
- diagLoad  out  1  DIAG_LOAD_FUNC_05x strobe
- diagRead  out  1  DIAG_READ_FUNC_14x enable
- ebusOut  out  36  [0:35] data driven for load/write steps
- ebusDriving  out  1  high when ebusOut is valid
- ebusIn  in  36  [0:35] EBUS data, sampled during verify steps

## Operation
- Reset values: ready=1; all other outputs 0. Request registers are cleared.
- States: IDLE, ARB, SETUP, STROBE, READ, PAUSE, DONE.
- The step list is fixed at accept. Each entry gives the select value and the data driven:
  - 051: sel 1, ebusOut[0:5]=adr[5:10]
  - 052: sel 2, ebusOut[1:5]=adr[0:4], ebusOut[0]=0
  - VLO: sel 4 read, expect ebusIn[0:5]=adr[5:10]
  - VHI: sel 5 read, expect ebusIn[1:5]=adr[0:4] (bit 0 is parity and is ignored)
  - If reqWrite=1, four write steps follow in this order: W00 sel 7, W20 sel 6, W40 sel 5, W60 sel 4. Each drives ebusOut[0:19] from the matching 20-bit slice of the word; ebusOut[20:35]=0.
- IDLE→ARB on accept. ebusReq stays high from ARB until DONE inclusive. ARB→first step when ebusGrant is high.
- Load and write steps:
  - SETUP lasts 1 cycle: diagSel and ebusOut are driven and ebusDriving=1; diagLoad=0.
  - STROBE lasts STROBE_CYCLES cycles: diagLoad=1, with diagSel and ebusOut held.
- Verify steps: READ lasts READ_CYCLES cycles with diagRead=1, ebusDriving=0, and diagSel held. rdAdr is updated on the last cycle.
- On a verify mismatch, the remaining steps, including all writes, are skipped. The FSM goes to DONE with err=1.
- ebusGrant is sampled only at step boundaries. If grant is low at a boundary, go to PAUSE: diagLoad, diagRead and ebusDriving are 0, ebusReq stays 1. Resume at the next step's first cycle once grant returns.
- DONE lasts 1 cycle: done=1, then return to IDLE. A new req is not accepted in the DONE cycle.
- Only 051, 052, 14x and the write selects are ever issued. sel 0 and sel 3 are never driven.

## Timing
- Accept in cycle t with grant already high: ARB in t+1, first step in t+2.
- Step time N:
  - write request: N = 6·(1+STROBE_CYCLES) + 2·READ_CYCLES. done pulses at t+2+N; defaults give t+24.
  - address-only request: N = 2·(1+STROBE_CYCLES) + 2·READ_CYCLES. done pulses at t+12 with defaults.
- Each PAUSE cycle adds one cycle. A step is never cut short by a grant drop.
- Asynchronous reset mid-transaction: all strobes fall immediately. No done is generated and the state is IDLE after reset.
- diagSel and ebusOut change only on entry to SETUP or READ, never while diagLoad=1.

## Structure
- A shared package holds:
  - the step enum
  - the select constants SEL_FUNC051=1, SEL_FUNC052=2, SEL_RD_ADRLO=4, SEL_RD_ADRHI=5, SEL_W60=4, SEL_W40=5, SEL_W20=6, SEL_W00=7
  - the FSM state enum
  - the tCRADR type, which is reused
- One sub-module, `diag_step_timer`: a loadable down-counter that signals the last cycle of a phase. The top holds the FSM, step index and data muxing.

## Test plan
- Write: adr=11'h5A3, data=80'h0123456789ABCDEF0123, grant held high, bench echoes 6'h23 then {p,5'h16} → 051 data 6'h23, 052 data 5'h16, writes W00..W60 with slices 20'h01234, 20'h56789, 20'hABCDE, 20'hF0123; done at t+24, err=0.
- Address-only request, adr=11'h7FF → no diagLoad on sel 4–7; done at t+12; rdAdr=11'h7FF.
- Mismatch: bench returns 6'h00 on VLO for adr=11'h001 → no write strobes; done with err=1 at t+2+2·3+2=t+10 (VHI is skipped).
- Grant dropped during the W20 strobe for 3 cycles → W20 strobe completes; 3 PAUSE cycles with ebusReq=1 and no strobes; W40 setup then follows; done at t+27.
- rstN pulled low during STROBE of 052 → diagLoad=0 immediately; ready=1 after release; the next request runs normally.
- req held high during DONE → not accepted in the DONE cycle; accepted in the following IDLE cycle.

Source files
------------

// File: rtl/cram_diag_loader_pkg.sv
// rtl/cram_diag_loader_pkg.sv - shared types and select codes for the CRAM diagnostic loader
package cram_diag_loader_pkg;

    typedef logic [0:10] tCRADR;

    typedef enum logic [2:0] {
        STEP_051,
        STEP_052,
        STEP_VLO,
        STEP_VHI,
        STEP_W00,
        STEP_W20,
        STEP_W40,
        STEP_W60
    } step_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_SETUP,
        ST_STROBE,
        ST_READ,
        ST_PAUSE,
        ST_DONE
    } state_e;

    localparam logic [2:0] SEL_FUNC051  = 3'd1;
    localparam logic [2:0] SEL_FUNC052  = 3'd2;
    localparam logic [2:0] SEL_RD_ADRLO = 3'd4;
    localparam logic [2:0] SEL_RD_ADRHI = 3'd5;
    localparam logic [2:0] SEL_W60      = 3'd4;
    localparam logic [2:0] SEL_W40      = 3'd5;
    localparam logic [2:0] SEL_W20      = 3'd6;
    localparam logic [2:0] SEL_W00      = 3'd7;

    localparam int TIMER_W = 8;

    function automatic logic [2:0] step_sel(input step_e s);
        case (s)
            STEP_051: return SEL_FUNC051;
            STEP_052: return SEL_FUNC052;
            STEP_VLO: return SEL_RD_ADRLO;
            STEP_VHI: return SEL_RD_ADRHI;
            STEP_W00: return SEL_W00;
            STEP_W20: return SEL_W20;
            STEP_W40: return SEL_W40;
            default:  return SEL_W60;
        endcase
    endfunction

    // Steps run in enum order; the wrap past W60 is never taken.
    function automatic step_e step_next(input step_e s);
        return step_e'(s + 3'd1);
    endfunction

    function automatic logic step_is_read(input step_e s);
        return (s == STEP_VLO) || (s == STEP_VHI);
    endfunction

endpackage

// File: rtl/cram_diag_loader_step_timer.sv
// rtl/cram_diag_loader_step_timer.sv - loadable down-counter flagging the last cycle of a phase
module diag_step_timer
    import cram_diag_loader_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_last
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == '0);

endmodule

// File: rtl/cram_diag_loader.sv
// rtl/cram_diag_loader.sv - sequences CRA address load, CRADR readback verify and CRAM write strobes
module cram_diag_loader
    import cram_diag_loader_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int READ_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        req,
    output logic        ready,
    input  logic        reqWrite,
    input  logic [0:10] reqAdr,
    input  logic [0:79] reqData,
    output logic        done,
    output logic        err,
    output logic [0:10] rdAdr,
    output logic        ebusReq,
    input  logic        ebusGrant,
    output logic [4:6]  diagSel,
    output logic        diagLoad,
    output logic        diagRead,
    output logic [0:35] ebusOut,
    output logic        ebusDriving,
    input  logic [0:35] ebusIn
);

    localparam logic [TIMER_W-1:0] STROBE_LOAD = TIMER_W'(STROBE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] READ_LOAD   = TIMER_W'(READ_CYCLES - 1);

    state_e       r_state;
    state_e       w_next;
    step_e        r_step;
    step_e        w_tgt_step;
    logic         r_write;
    tCRADR        r_adr;
    logic [0:79]  r_data;
    logic         r_err;
    tCRADR        r_rd_adr;
    logic [2:0]   r_sel;
    logic [0:35]  r_ebus_out;

    logic               w_last;
    logic               w_in_phase;
    logic               w_phase_end;
    logic               w_final;
    logic               w_mismatch;
    logic               w_tgt_read;
    logic               w_enter;
    logic               w_tmr_load;
    logic [TIMER_W-1:0] w_tmr_value;
    logic [0:35]        w_step_data;
    state_e             w_first_state;
    logic               w_unused;

    assign w_unused = ^ebusIn[6:35];

    assign w_in_phase    = (r_state == ST_STROBE) || (r_state == ST_READ);
    assign w_phase_end   = w_in_phase && w_last;
    assign w_final       = (r_step == (r_write ? STEP_W60 : STEP_VHI));
    // The step being entered: the following one at a phase end, else the held one.
    assign w_tgt_step    = w_in_phase ? step_next(r_step) : r_step;
    assign w_tgt_read    = step_is_read(w_tgt_step);
    assign w_first_state = w_tgt_read ? ST_READ : ST_SETUP;

    always_comb begin
        w_mismatch = 1'b0;
        if (r_step == STEP_VLO) begin
            w_mismatch = (ebusIn[0:5] != r_adr[5:10]);
        end else if (r_step == STEP_VHI) begin
            w_mismatch = (ebusIn[1:5] != r_adr[0:4]);
        end
    end

    always_comb begin
        w_step_data = '0;
        case (w_tgt_step)
            STEP_051: w_step_data = {r_adr[5:10], 30'h0};
            STEP_052: w_step_data = {1'b0, r_adr[0:4], 30'h0};
            STEP_W00: w_step_data = {r_data[0:19], 16'h0};
            STEP_W20: w_step_data = {r_data[20:39], 16'h0};
            STEP_W40: w_step_data = {r_data[40:59], 16'h0};
            STEP_W60: w_step_data = {r_data[60:79], 16'h0};
            default:  w_step_data = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (req) w_next = ST_ARB;
            ST_ARB:    if (ebusGrant) w_next = w_first_state;
            ST_SETUP:  w_next = ST_STROBE;
            ST_STROBE,
            ST_READ: begin
                if (w_last) begin
                    if (w_final || (r_state == ST_READ && w_mismatch)) begin
                        w_next = ST_DONE;
                    end else if (ebusGrant) begin
                        w_next = w_first_state;
                    end else begin
                        w_next = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE:  if (ebusGrant) w_next = w_first_state;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign w_enter     = (w_next == ST_SETUP && r_state != ST_SETUP) ||
                         (w_next == ST_READ && (r_state != ST_READ || w_last));
    assign w_tmr_load  = !w_in_phase || w_last;
    assign w_tmr_value = (w_next == ST_READ) ? READ_LOAD : STROBE_LOAD;

    diag_step_timer #(
        .W(TIMER_W)
    ) u_timer (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_step     <= STEP_051;
            r_write    <= 1'b0;
            r_adr      <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
            r_rd_adr   <= '0;
            r_sel      <= '0;
            r_ebus_out <= '0;
        end else begin
            if (r_state == ST_IDLE && req) begin
                r_step  <= STEP_051;
                r_write <= reqWrite;
                r_adr   <= reqAdr;
                r_data  <= reqData;
                r_err   <= 1'b0;
            end
            if (w_phase_end && w_next != ST_DONE) begin
                r_step <= step_next(r_step);
            end
            if (r_state == ST_READ && w_last) begin
                if (r_step == STEP_VLO) begin
                    r_rd_adr[5:10] <= ebusIn[0:5];
                end else begin
                    r_rd_adr[0:4] <= ebusIn[1:5];
                end
                if (w_mismatch) begin
                    r_err <= 1'b1;
                end
            end
            // Select and data move only when a step's first phase begins.
            if (w_enter) begin
                r_sel      <= step_sel(w_tgt_step);
                r_ebus_out <= w_tgt_read ? '0 : w_step_data;
            end
        end
    end

    assign ready       = (r_state == ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign err         = (r_state == ST_DONE) && r_err;
    assign rdAdr       = r_rd_adr;
    assign ebusReq     = (r_state != ST_IDLE);
    assign diagSel     = r_sel;
    assign diagLoad    = (r_state == ST_STROBE);
    assign diagRead    = (r_state == ST_READ);
    assign ebusOut     = r_ebus_out;
    assign ebusDriving = (r_state == ST_SETUP) || (r_state == ST_STROBE);

endmodule

// File: tb/tb_cram_diag_loader.sv
// tb/tb_cram_diag_loader.sv - directed self-checking bench for cram_diag_loader
module tb_cram_diag_loader;

    logic        clk = 1'b0;
    logic        rstN;
    logic        req;
    logic        ready;
    logic        reqWrite;
    logic [0:10] reqAdr;
    logic [0:79] reqData;
    logic        done;
    logic        err;
    logic [0:10] rdAdr;
    logic        ebusReq;
    logic        ebusGrant;
    logic [4:6]  diagSel;
    logic        diagLoad;
    logic        diagRead;
    logic [0:35] ebusOut;
    logic        ebusDriving;
    logic [0:35] ebusIn;

    logic [0:35] resp_lo;
    logic [0:35] resp_hi;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ebusIn = !diagRead ? 36'h0 : (diagSel == 3'd4) ? resp_lo : resp_hi;

    cram_diag_loader #(
        .STROBE_CYCLES(2),
        .READ_CYCLES  (2)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .req        (req),
        .ready      (ready),
        .reqWrite   (reqWrite),
        .reqAdr     (reqAdr),
        .reqData    (reqData),
        .done       (done),
        .err        (err),
        .rdAdr      (rdAdr),
        .ebusReq    (ebusReq),
        .ebusGrant  (ebusGrant),
        .diagSel    (diagSel),
        .diagLoad   (diagLoad),
        .diagRead   (diagRead),
        .ebusOut    (ebusOut),
        .ebusDriving(ebusDriving),
        .ebusIn     (ebusIn)
    );

    // Bus activity log, sampled on the falling edge.
    logic [2:0]  lg_sel [64];
    logic [0:35] lg_dat [64];
    int          n_strobe   = 0;
    int          n_load_cyc = 0;
    int          n_quiet    = 0;
    int          n_sel_chg  = 0;
    int          n_wsel     = 0;
    int          n_done     = 0;
    logic        prev_load  = 1'b0;
    logic [2:0]  prev_sel   = 3'd0;
    logic [0:35] prev_dat   = 36'h0;

    always @(negedge clk) begin
        if (diagLoad && !prev_load) begin
            lg_sel[n_strobe[5:0]] <= diagSel;
            lg_dat[n_strobe[5:0]] <= ebusOut;
            n_strobe <= n_strobe + 1;
        end
        if (diagLoad) n_load_cyc <= n_load_cyc + 1;
        if (diagLoad && diagSel >= 3'd4) n_wsel <= n_wsel + 1;
        if (diagLoad && prev_load && (diagSel != prev_sel || ebusOut != prev_dat))
            n_sel_chg <= n_sel_chg + 1;
        if (ebusReq && !diagLoad && !diagRead && !ebusDriving) n_quiet <= n_quiet + 1;
        if (done) n_done <= n_done + 1;
        prev_load <= diagLoad;
        prev_sel  <= diagSel;
        prev_dat  <= ebusOut;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [0:10] adr, input logic [0:79] data, input logic wr);
        reqAdr   = adr;
        reqData  = data;
        reqWrite = wr;
        req      = 1'b1;
    endtask

    task automatic wait_done(input logic hold, input int drop_at, input int drop_len,
                             output int k);
        k = 0;
        while (k < 60) begin
            tick();
            k++;
            if (!hold) req = 1'b0;
            if (k == drop_at) ebusGrant = 1'b0;
            if (k == drop_at + drop_len) ebusGrant = 1'b1;
            if (drop_len > 0 && k == drop_at + 2) begin
                check("pause_req",  ebusReq, 1'b1);
                check("pause_load", diagLoad, 1'b0);
                check("pause_drv",  ebusDriving, 1'b0);
            end
            if (done) break;
        end
    endtask

    logic [2:0]  exp_sel [6];
    logic [0:35] exp_dat [6];
    int          k;
    int          b_strobe, b_load, b_quiet, b_wsel, b_done;
    logic [5:0]  idx;

    initial begin
        rstN = 1'b0; req = 1'b0; reqWrite = 1'b0; reqAdr = '0; reqData = '0;
        ebusGrant = 1'b1; resp_lo = '0; resp_hi = '0;
        exp_sel[0] = 3'd1; exp_dat[0] = {6'h23, 30'h0};
        exp_sel[1] = 3'd2; exp_dat[1] = {1'b0, 5'h16, 30'h0};
        exp_sel[2] = 3'd7; exp_dat[2] = {20'h01234, 16'h0};
        exp_sel[3] = 3'd6; exp_dat[3] = {20'h56789, 16'h0};
        exp_sel[4] = 3'd5; exp_dat[4] = {20'hABCDE, 16'h0};
        exp_sel[5] = 3'd4; exp_dat[5] = {20'hF0123, 16'h0};

        repeat (3) tick();
        check("rst_ready", ready, 1'b1);
        check("rst_done",  done, 1'b0);
        check("rst_err",   err, 1'b0);
        check("rst_ebreq", ebusReq, 1'b0);
        check("rst_load",  diagLoad, 1'b0);
        check("rst_read",  diagRead, 1'b0);
        check("rst_drv",   ebusDriving, 1'b0);
        check("rst_sel",   diagSel, 3'd0);
        check("rst_out",   ebusOut, 36'h0);
        check("rst_rdadr", rdAdr, 11'h0);
        rstN = 1'b1;
        tick();

        // Full write with readback matching; parity bit set on VHI to confirm it is ignored.
        resp_lo = {6'h23, 30'h0};
        resp_hi = {1'b1, 5'h16, 30'h0};
        b_strobe = n_strobe; b_load = n_load_cyc; b_quiet = n_quiet;
        issue(11'h5A3, 80'h0123456789ABCDEF0123, 1'b1);
        wait_done(1'b0, 0, 0, k);
        check("wr_done_cycle", k, 24);
        check("wr_err", err, 1'b0);
        tick();
        check("wr_done_pulse", done, 1'b0);
        check("wr_ready", ready, 1'b1);
        check("wr_rdadr", rdAdr, 11'h5A3);
        check("wr_nstrobe", n_strobe - b_strobe, 6);
        check("wr_loadcyc", n_load_cyc - b_load, 12);
        check("wr_quiet", n_quiet - b_quiet, 2);
        for (int i = 0; i < 6; i++) begin
            idx = 6'(b_strobe + i);
            check($sformatf("wr_sel%0d", i), lg_sel[idx], exp_sel[i]);
            check($sformatf("wr_dat%0d", i), lg_dat[idx], exp_dat[i]);
        end

        // Address-only load of 7FF.
        resp_lo = {6'h3F, 30'h0};
        resp_hi = {1'b0, 5'h1F, 30'h0};
        b_strobe = n_strobe; b_wsel = n_wsel;
        issue(11'h7FF, 80'h0, 1'b0);
        wait_done(1'b0, 0, 0, k);
        check("ad_done_cycle", k, 12);
        check("ad_err", err, 1'b0);
        tick();
        check("ad_rdadr", rdAdr, 11'h7FF);
        check("ad_nstrobe", n_strobe - b_strobe, 2);
        check("ad_wsel", n_wsel - b_wsel, 0);

        // Readback mismatch on VLO aborts before any write strobe.
        resp_lo = 36'h0;
        resp_hi = {1'b0, 5'h00, 30'h0};
        b_strobe = n_strobe; b_wsel = n_wsel;
        issue(11'h001, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_done(1'b0, 0, 0, k);
        check("mm_done_cycle", k, 10);
        check("mm_err", err, 1'b1);
        tick();
        check("mm_nstrobe", n_strobe - b_strobe, 2);
        check("mm_wsel", n_wsel - b_wsel, 0);

        // Grant dropped in the last W20 strobe cycle for three boundary samples.
        resp_lo = {6'h23, 30'h0};
        resp_hi = {1'b0, 5'h16, 30'h0};
        b_strobe = n_strobe; b_load = n_load_cyc; b_quiet = n_quiet;
        issue(11'h5A3, 80'h0123456789ABCDEF0123, 1'b1);
        wait_done(1'b0, 17, 3, k);
        check("ps_done_cycle", k, 27);
        check("ps_err", err, 1'b0);
        tick();
        check("ps_loadcyc", n_load_cyc - b_load, 12);
        check("ps_quiet", n_quiet - b_quiet, 5);
        idx = 6'(b_strobe + 4);
        check("ps_w40_sel", lg_sel[idx], 3'd5);
        check("ps_w40_dat", lg_dat[idx], {20'hABCDE, 16'h0});

        // Asynchronous reset during the 052 strobe.
        b_done = n_done;
        issue(11'h5A3, 80'h0123456789ABCDEF0123, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            req = 1'b0;
        end
        check("ar_in_strobe", diagLoad, 1'b1);
        check("ar_sel052", diagSel, 3'd2);
        rstN = 1'b0;
        #1;
        check("ar_load_fall", diagLoad, 1'b0);
        check("ar_ebreq_fall", ebusReq, 1'b0);
        tick();
        rstN = 1'b1;
        tick();
        check("ar_ready", ready, 1'b1);
        tick();
        check("ar_no_done", n_done - b_done, 0);
        resp_lo = {6'h3F, 30'h0};
        resp_hi = {1'b0, 5'h1F, 30'h0};
        issue(11'h7FF, 80'h0, 1'b0);
        wait_done(1'b0, 0, 0, k);
        check("ar_next_done", k, 12);
        check("ar_next_err", err, 1'b0);
        tick();
        check("ar_next_rdadr", rdAdr, 11'h7FF);

        // req held through DONE: second accept only in the following IDLE cycle.
        issue(11'h7FF, 80'h0, 1'b0);
        wait_done(1'b1, 0, 0, k);
        check("hd_done_cycle", k, 12);
        check("hd_ready_in_done", ready, 1'b0);
        tick();
        check("hd_idle_ready", ready, 1'b1);
        check("hd_idle_ebreq", ebusReq, 1'b0);
        tick();
        check("hd_accepted", ebusReq, 1'b1);
        req = 1'b0;
        wait_done(1'b0, 0, 0, k);
        check("hd_second_done", k, 11);
        tick();

        check("sel_stable_in_strobe", n_sel_chg, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
